// File: rtl/ram_pkg.sv
// Shared types, read-during-write mode constants and the byte-merge helper
// for the dual-port RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // The helper works on a wide fixed word so any DATA_WIDTH up to MERGE_W can
    // use it; callers zero-extend their operands and truncate the result.
    localparam int MERGE_W    = 1024;
    localparam int MERGE_BE_W = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] merge_be(
        input logic [MERGE_W-1:0]    old_word,
        input logic [MERGE_W-1:0]    new_word,
        input logic [MERGE_BE_W-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_word;
        for (int i = 0; i < MERGE_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-data / read-valid output pipeline, READ_LATENCY stages deep.
// Stage 0 only loads on an access, later stages follow it one cycle behind.
module ram_rd_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    logic [DATA_WIDTH-1:0]   data_reg [READ_LATENCY];
    logic [READ_LATENCY-1:0] valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_reg[i] <= '0;
            end
            valid_reg <= '0;
        end else begin
            valid_reg[0] <= valid;
            if (load) begin
                data_reg[0] <= data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                data_reg[i]  <= data_reg[i-1];
            end
        end
    end

    assign rdata  = data_reg[READ_LATENCY-1];
    assign rvalid = valid_reg[READ_LATENCY-1];

endmodule

// File: rtl/ram_dp_sr_sw.sv
// True dual-port RAM, one clock: byte-enable writes, selectable read-during-write,
// configurable read latency, write-collision flag and a post-reset zero-fill sweep.
module ram_dp_sr_sw
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_cs,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_cs,
    input  logic                    b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    init_busy,
    output logic                    collision
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int NB        = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    state_t              state_reg;
    logic [ADDR_WIDTH:0] clr_cnt_reg;
    logic [ADDR_WIDTH:0] clr_cnt_next;
    logic                init_busy_reg;
    logic                collision_reg;

    logic run;
    logic a_load, a_wr, a_rd;
    logic b_load, b_wr, b_rd;

    assign run    = (state_reg == RUN);
    assign a_load = run & a_cs;
    assign a_wr   = a_load & a_we;
    assign a_rd   = a_load & ~a_we;
    assign b_load = run & b_cs;
    assign b_wr   = b_load & b_we;
    assign b_rd   = b_load & ~b_we;

    // Carry into the extra counter bit marks the write to the last address.
    assign clr_cnt_next = clr_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_cnt_reg   <= '0;
            init_busy_reg <= (CLEAR_ON_RESET != 0);
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= a_wr & b_wr & (a_addr == b_addr);
            if (state_reg == CLEAR) begin
                clr_cnt_reg <= clr_cnt_next;
                if (clr_cnt_next[ADDR_WIDTH]) begin
                    state_reg     <= RUN;
                    init_busy_reg <= 1'b0;
                end
            end
        end
    end

    // Port B is applied first so port A wins on bytes both ports enable.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt_reg[ADDR_WIDTH-1:0]] <= '0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (b_wr && b_be[i]) begin
                    mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                end
            end
            for (int i = 0; i < NB; i++) begin
                if (a_wr && a_be[i]) begin
                    mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_WIDTH-1:0] a_old, b_old, a_rd_word, b_rd_word;

    assign a_old = mem[a_addr];
    assign b_old = mem[b_addr];

    // A write loads rdata with the read-during-write word but raises no rvalid.
    assign a_rd_word = (RDW_MODE == RDW_WRITE_FIRST && a_we)
        ? DATA_WIDTH'(merge_be(MERGE_W'(a_old), MERGE_W'(a_wdata), MERGE_BE_W'(a_be)))
        : a_old;
    assign b_rd_word = (RDW_MODE == RDW_WRITE_FIRST && b_we)
        ? DATA_WIDTH'(merge_be(MERGE_W'(b_old), MERGE_W'(b_wdata), MERGE_BE_W'(b_be)))
        : b_old;

    ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_a_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (a_load),
        .valid (a_rd),
        .data  (a_rd_word),
        .rdata (a_rdata),
        .rvalid(a_rvalid)
    );

    ram_rd_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_b_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (b_load),
        .valid (b_rd),
        .data  (b_rd_word),
        .rdata (b_rdata),
        .rvalid(b_rvalid)
    );

    assign init_busy = init_busy_reg;
    assign collision = collision_reg;

endmodule

// File: tb/tb_ram_dp_sr_sw.sv
// Bench for ram_dp_sr_sw: two instances (latency 1 / read-first, latency 2 / write-first)
// share one stimulus stream and are checked against a word-level memory model.
module tb_ram_dp_sr_sw;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NB = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_cs = 0, a_we = 0, b_cs = 0, b_we = 0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [NB-1:0] a_be = '0, b_be = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;

    logic [DW-1:0] a_rdata [2];
    logic [DW-1:0] b_rdata [2];
    logic          a_rvalid [2];
    logic          b_rvalid [2];
    logic          init_busy [2];
    logic          collision [2];

    ram_dp_sr_sw #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_rdata(a_rdata[0]), .a_rvalid(a_rvalid[0]),
        .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]),
        .init_busy(init_busy[0]), .collision(collision[0])
    );

    ram_dp_sr_sw #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
        .a_rdata(a_rdata[1]), .a_rvalid(a_rvalid[1]),
        .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]),
        .init_busy(init_busy[1]), .collision(collision[1])
    );

    typedef struct {
        int            due;
        bit            rd;
        logic [DW-1:0] data;
    } ev_t;

    int            n_chk = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            busy_left = 0;
    int            lat [2] = '{1, 2};
    int            rdw [2] = '{0, 1};
    logic [DW-1:0] mdl_mem [DEPTH];
    ev_t           evq [2][2][$];
    logic [DW-1:0] exp_rdata [2][2];
    bit            exp_valid [2][2];
    bit            exp_coll = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic set_a(input logic cs, input logic we, input logic [AW-1:0] addr,
                         input logic [NB-1:0] be, input logic [DW-1:0] wd);
        a_cs = cs; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
    endtask

    task automatic set_b(input logic cs, input logic we, input logic [AW-1:0] addr,
                         input logic [NB-1:0] be, input logic [DW-1:0] wd);
        b_cs = cs; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
    endtask

    task automatic idle();
        set_a(0, 0, '0, '0, '0);
        set_b(0, 0, '0, '0, '0);
    endtask

    // One clock: update the model from the driven inputs, clock, then check every output.
    task automatic step();
        ev_t           ev;
        logic [DW-1:0] old_a, old_b;
        exp_coll = 1'b0;
        if (busy_left == 0) begin
            old_a = mdl_mem[a_addr];
            old_b = mdl_mem[b_addr];
            for (int d = 0; d < 2; d++) begin
                if (a_cs) begin
                    ev.due = cyc + lat[d];
                    ev.rd = !a_we;
                    ev.data = (a_we && rdw[d] == 1) ? merge(old_a, a_wdata, a_be) : old_a;
                    evq[d][0].push_back(ev);
                end
                if (b_cs) begin
                    ev.due = cyc + lat[d];
                    ev.rd = !b_we;
                    ev.data = (b_we && rdw[d] == 1) ? merge(old_b, b_wdata, b_be) : old_b;
                    evq[d][1].push_back(ev);
                end
            end
            if (b_cs && b_we) mdl_mem[b_addr] = merge(mdl_mem[b_addr], b_wdata, b_be);
            if (a_cs && a_we) mdl_mem[a_addr] = merge(mdl_mem[a_addr], a_wdata, a_be);
            exp_coll = a_cs && a_we && b_cs && b_we && (a_addr == b_addr);
        end else begin
            busy_left--;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                exp_valid[d][p] = 1'b0;
                while (evq[d][p].size() > 0 && evq[d][p][0].due == cyc) begin
                    ev = evq[d][p].pop_front();
                    exp_rdata[d][p] = ev.data;
                    exp_valid[d][p] = ev.rd;
                end
            end
            chk($sformatf("d%0d_a_rdata", d), a_rdata[d], exp_rdata[d][0]);
            chk($sformatf("d%0d_a_rvalid", d), a_rvalid[d], exp_valid[d][0]);
            chk($sformatf("d%0d_b_rdata", d), b_rdata[d], exp_rdata[d][1]);
            chk($sformatf("d%0d_b_rvalid", d), b_rvalid[d], exp_valid[d][1]);
            chk($sformatf("d%0d_init_busy", d), init_busy[d], busy_left > 0);
            chk($sformatf("d%0d_collision", d), collision[d], exp_coll);
        end
    endtask

    // Async reset in the middle of the low phase; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_d%0d_a_rdata", d), a_rdata[d], 16'h0);
            chk($sformatf("rst_d%0d_a_rvalid", d), a_rvalid[d], 1'b0);
            chk($sformatf("rst_d%0d_b_rdata", d), b_rdata[d], 16'h0);
            chk($sformatf("rst_d%0d_b_rvalid", d), b_rvalid[d], 1'b0);
            chk($sformatf("rst_d%0d_collision", d), collision[d], 1'b0);
            chk($sformatf("rst_d%0d_init_busy", d), init_busy[d], 1'b1);
            for (int p = 0; p < 2; p++) begin
                evq[d][p].delete();
                exp_rdata[d][p] = '0;
                exp_valid[d][p] = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        busy_left = DEPTH;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sweep with junk writes pending; busy must last exactly DEPTH cycles.
    task automatic sweep(input string tag);
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (init_busy[0]) busy_cnt++;
            set_a(1, 1, AW'(i), '1, 16'hBEEF);
            set_b(1, 0, AW'(i), '0, '0);
            step();
            if (busy_left == 0) break;
        end
        idle();
        chk(tag, busy_cnt, DEPTH);
    endtask

    task automatic rd_expect(input int p, input logic [AW-1:0] addr, input logic [DW-1:0] val,
                             input string tag);
        idle();
        if (p == 0) set_a(1, 0, addr, '0, '0);
        else set_b(1, 0, addr, '0, '0);
        step();
        chk({tag, "_d0"}, (p == 0) ? a_rdata[0] : b_rdata[0], val);
        chk({tag, "_d0_v"}, (p == 0) ? a_rvalid[0] : b_rvalid[0], 1'b1);
        idle();
        step();
        chk({tag, "_d1"}, (p == 0) ? a_rdata[1] : b_rdata[1], val);
        chk({tag, "_d1_v"}, (p == 0) ? a_rvalid[1] : b_rvalid[1], 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        // Test 1: sweep length, writes ignored while busy, all words read back as zero
        do_reset();
        sweep("busy_len");
        for (int i = 0; i < DEPTH; i++) begin
            set_a(1, 0, AW'(i), '0, '0);
            set_b(1, 0, AW'(DEPTH - 1 - i), '0, '0);
            step();
        end
        idle();
        step();
        step();

        // Test 2: cross-port write then read, both directions
        set_a(1, 1, 4'h3, 2'b11, 16'hAAAA);
        step();
        rd_expect(1, 4'h3, 16'hAAAA, "b_rd_after_a_wr");
        idle();
        set_b(1, 1, 4'h3, 2'b11, 16'h5A5A);
        step();
        rd_expect(0, 4'h3, 16'h5A5A, "a_rd_after_b_wr");

        // Test 3: byte-enable partial write
        idle();
        set_a(1, 1, 4'h5, 2'b11, 16'h1234);
        step();
        set_a(1, 1, 4'h5, 2'b01, 16'hFFFF);
        step();
        rd_expect(0, 4'h5, 16'h12FF, "be_merge");

        // Test 4: same-port read-during-write
        idle();
        set_a(1, 1, 4'h7, 2'b11, 16'h1111);
        step();
        set_a(1, 1, 4'h7, 2'b11, 16'h2222);
        step();
        chk("rdw_read_first", a_rdata[0], 16'h1111);
        idle();
        step();
        chk("rdw_write_first", a_rdata[1], 16'h2222);

        // Test 5: write/write collision and write/read on the same address
        set_a(1, 1, 4'h9, 2'b11, 16'hAAAA);
        set_b(1, 1, 4'h9, 2'b11, 16'h5555);
        step();
        chk("coll_pulse_d0", collision[0], 1'b1);
        chk("coll_pulse_d1", collision[1], 1'b1);
        idle();
        step();
        chk("coll_once", collision[0], 1'b0);
        rd_expect(1, 4'h9, 16'hAAAA, "coll_a_wins");
        set_a(1, 1, 4'h9, 2'b11, 16'h1357);
        set_b(1, 0, 4'h9, '0, '0);
        step();
        chk("wr_rd_old_d0", b_rdata[0], 16'hAAAA);
        idle();
        step();
        chk("wr_rd_old_d1", b_rdata[1], 16'hAAAA);

        // Test 6: reset mid-sweep, then reset with a read in flight
        do_reset();
        for (int i = 0; i < 5; i++) step();
        do_reset();
        sweep("busy_len_restart");
        set_a(1, 1, 4'h2, 2'b11, 16'h0077);
        step();
        set_a(1, 0, 4'h2, '0, '0);
        step();
        idle();
        do_reset();
        sweep("busy_len_after_rd");
        for (int i = 0; i < 3; i++) step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            set_a($urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1)),
                  NB'($urandom), DW'($urandom));
            set_b($urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1)),
                  NB'($urandom), DW'($urandom));
            step();
        end
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
